// File: rtl/debounce_bank.sv
// Multi-channel switch debouncer: synchroniser, stability counter, edge pulses,
// selectable-edge toggle and optional one-shot long-hold pulse per channel.
module debounce_bank #(
  parameter int   NUM_CH          = 4,
  parameter int   SYNC_STAGES     = 2,
  parameter int   DEBOUNCE_CYCLES = 50000,
  parameter int   LONG_CYCLES     = 0,
  parameter logic RESET_LEVEL     = 1'b1,
  parameter logic ACTIVE_LEVEL    = 1'b0
) (
  input  logic              CLK,
  input  logic              RST,
  input  logic [NUM_CH-1:0] switch_in,
  input  logic [NUM_CH-1:0] toggle_edge_sel,
  output logic [NUM_CH-1:0] state,
  output logic [NUM_CH-1:0] trans_up,
  output logic [NUM_CH-1:0] trans_dn,
  output logic [NUM_CH-1:0] toggle,
  output logic [NUM_CH-1:0] long_hold
);

  localparam int             DW      = $clog2(DEBOUNCE_CYCLES + 1);
  localparam logic [DW-1:0]  DB_LAST = DW'(DEBOUNCE_CYCLES - 1);

  for (genvar i = 0; i < NUM_CH; i++) begin : g_ch
    logic [SYNC_STAGES-1:0] sync_q;
    logic [DW-1:0]          db_cnt;
    logic                   state_q;
    logic                   up_q;
    logic                   dn_q;
    logic                   tog_q;
    logic                   sync;
    logic                   accept;

    assign sync   = sync_q[SYNC_STAGES-1];
    assign accept = (sync != state_q) && (db_cnt == DB_LAST);

    always_ff @(posedge CLK or posedge RST) begin
      if (RST) begin
        sync_q <= {SYNC_STAGES{RESET_LEVEL}};
      end else begin
        sync_q <= {sync_q[SYNC_STAGES-2:0], switch_in[i]};
      end
    end

    // Any cycle where sync agrees with the accepted level restarts the count.
    always_ff @(posedge CLK or posedge RST) begin
      if (RST) begin
        db_cnt  <= '0;
        state_q <= RESET_LEVEL;
        up_q    <= 1'b0;
        dn_q    <= 1'b0;
        tog_q   <= 1'b0;
      end else begin
        up_q <= accept && sync;
        dn_q <= accept && !sync;
        if (sync == state_q) begin
          db_cnt <= '0;
        end else if (accept) begin
          db_cnt  <= '0;
          state_q <= sync;
          if (sync == toggle_edge_sel[i]) begin
            tog_q <= ~tog_q;
          end
        end else begin
          db_cnt <= db_cnt + 1'b1;
        end
      end
    end

    assign state[i]    = state_q;
    assign trans_up[i] = up_q;
    assign trans_dn[i] = dn_q;
    assign toggle[i]   = tog_q;

    if (LONG_CYCLES > 0) begin : g_hold
      localparam int            HW        = $clog2(LONG_CYCLES + 1);
      localparam logic [HW-1:0] HOLD_MAX  = HW'(LONG_CYCLES);
      localparam logic [HW-1:0] HOLD_LAST = HW'(LONG_CYCLES - 1);
      logic [HW-1:0] hold_cnt;
      logic          long_q;

      // Saturating at HOLD_MAX keeps the pulse to one per press.
      always_ff @(posedge CLK or posedge RST) begin
        if (RST) begin
          hold_cnt <= '0;
          long_q   <= 1'b0;
        end else if (state_q != ACTIVE_LEVEL) begin
          hold_cnt <= '0;
          long_q   <= 1'b0;
        end else begin
          long_q <= (hold_cnt == HOLD_LAST);
          if (hold_cnt != HOLD_MAX) begin
            hold_cnt <= hold_cnt + 1'b1;
          end
        end
      end

      assign long_hold[i] = long_q;
    end else begin : g_no_hold
      assign long_hold[i] = 1'b0;
    end
  end

endmodule

// File: tb/tb_debounce_bank.sv
// Bench for debounce_bank: directed scenarios plus randomized traffic against a
// run-length reference model; a second instance covers the unfiltered corner.
module tb_debounce_bank;

  logic       CLK;
  logic       RST;
  logic [1:0] sw, sel;
  logic [1:0] st, tu, td, tg, lh;
  logic       sw_b, sel_b;
  logic       st_b, tu_b, td_b, tg_b, lh_b;

  int n_vec = 0;
  int n_err = 0;

  debounce_bank #(
    .NUM_CH(2), .SYNC_STAGES(2), .DEBOUNCE_CYCLES(8), .LONG_CYCLES(20),
    .RESET_LEVEL(1'b1), .ACTIVE_LEVEL(1'b0)
  ) dut_a (
    .CLK(CLK), .RST(RST), .switch_in(sw), .toggle_edge_sel(sel),
    .state(st), .trans_up(tu), .trans_dn(td), .toggle(tg), .long_hold(lh)
  );

  debounce_bank #(
    .NUM_CH(1), .SYNC_STAGES(2), .DEBOUNCE_CYCLES(1), .LONG_CYCLES(0),
    .RESET_LEVEL(1'b1), .ACTIVE_LEVEL(1'b0)
  ) dut_b (
    .CLK(CLK), .RST(RST), .switch_in(sw_b), .toggle_edge_sel(sel_b),
    .state(st_b), .trans_up(tu_b), .trans_dn(td_b), .toggle(tg_b), .long_hold(lh_b)
  );

  initial CLK = 1'b0;
  always #5 CLK = ~CLK;

  // Reference model: the raw level seen by the filter lags two edges; a level is
  // accepted once it has differed from the current one for 8 edges in a row.
  logic [1:0] m_state, m_up, m_dn, m_tog, m_long;
  logic [1:0] m_pipe[$];
  int         m_run[2];
  int         m_age[2];

  task automatic model_reset();
    m_state = 2'b11; m_up = 2'b00; m_dn = 2'b00; m_tog = 2'b00; m_long = 2'b00;
    m_pipe = '{2'b11, 2'b11};
    for (int c = 0; c < 2; c++) begin m_run[c] = 0; m_age[c] = 0; end
  endtask

  task automatic model_step();
    logic [1:0] d;
    d = m_pipe.pop_front();
    m_pipe.push_back(sw);
    for (int c = 0; c < 2; c++) begin
      m_up[c] = 1'b0;
      m_dn[c] = 1'b0;
      if (m_state[c] == 1'b0) begin
        m_age[c]++;
        m_long[c] = (m_age[c] == 20);
      end else begin
        m_age[c]  = 0;
        m_long[c] = 1'b0;
      end
      if (d[c] != m_state[c]) begin
        m_run[c]++;
        if (m_run[c] == 8) begin
          m_run[c]   = 0;
          m_state[c] = d[c];
          if (d[c]) m_up[c] = 1'b1; else m_dn[c] = 1'b1;
          if (d[c] == sel[c]) m_tog[c] = ~m_tog[c];
        end
      end else begin
        m_run[c] = 0;
      end
    end
  endtask

  task automatic tick();
    @(posedge CLK);
    if (RST) model_reset(); else model_step();
    #1;
  endtask

  task automatic test_reset();
    RST = 1'b0; sw = 2'b11; sel = 2'b10; sw_b = 1'b1; sel_b = 1'b0;
    model_reset();
    #1 RST = 1'b1;
    #2;
    n_vec++;
    if ({st, tu, td, tg, lh} !== 10'b11_00_00_00_00) begin
      n_err++; $display("FAIL reset_a got %b want %b", {st, tu, td, tg, lh}, 10'b11_00_00_00_00);
    end
    n_vec++;
    if ({st_b, tu_b, td_b, tg_b, lh_b} !== 5'b10000) begin
      n_err++; $display("FAIL reset_b got %b want %b", {st_b, tu_b, td_b, tg_b, lh_b}, 5'b10000);
    end
    tick(); tick();
    RST = 1'b0;
    for (int k = 0; k < 5; k++) begin
      tick();
      n_vec++;
      if ({st, tu, td, tg, lh} !== {m_state, m_up, m_dn, m_tog, m_long}) begin
        n_err++; $display("FAIL reset_idle k=%0d got %b want %b", k, {st, tu, td, tg, lh}, {m_state, m_up, m_dn, m_tog, m_long});
      end
    end
  endtask

  task automatic test_clean_press();
    logic [4:0] exp;
    sw[0] = 1'b0;
    for (int k = 1; k <= 12; k++) begin
      tick();
      // {state0, trans_dn0, trans_up0, toggle0, long0} and all ch1 outputs idle
      exp = {(k < 10), (k == 10), 1'b0, (k >= 10), 1'b0};
      n_vec++;
      if ({st[0], td[0], tu[0], tg[0], lh[0], st[1], td[1], tu[1], tg[1], lh[1]} !== {exp, 5'b10000}) begin
        n_err++; $display("FAIL clean_press k=%0d got %b want %b", k,
          {st[0], td[0], tu[0], tg[0], lh[0], st[1], td[1], tu[1], tg[1], lh[1]}, {exp, 5'b10000});
      end
      n_vec++;
      if ({st, tu, td, tg, lh} !== {m_state, m_up, m_dn, m_tog, m_long}) begin
        n_err++; $display("FAIL clean_model k=%0d got %b want %b", k, {st, tu, td, tg, lh}, {m_state, m_up, m_dn, m_tog, m_long});
      end
    end
    sw[0] = 1'b1;
    for (int k = 0; k < 15; k++) tick();
  endtask

  task automatic test_bounce();
    int   seg_len[4] = '{5, 2, 6, 15};
    logic tog0;
    tog0 = m_tog[0];
    for (int s = 0; s < 4; s++) begin
      sw[0] = s[0];
      for (int k = 0; k < seg_len[s]; k++) begin
        tick();
        n_vec++;
        if ({st[0], tu[0], td[0], lh[0], tg[0]} !== {4'b1000, tog0}) begin
          n_err++; $display("FAIL bounce s=%0d k=%0d got %b want %b", s, k, {st[0], tu[0], td[0], lh[0], tg[0]}, {4'b1000, tog0});
        end
      end
    end
    sw[0] = 1'b0;
    for (int k = 1; k <= 12; k++) begin
      tick();
      n_vec++;
      if ({st[0], td[0], tu[0]} !== {(k < 10), (k == 10), 1'b0}) begin
        n_err++; $display("FAIL bounce_settle k=%0d got %b want %b", k, {st[0], td[0], tu[0]}, {(k < 10), (k == 10), 1'b0});
      end
    end
    sw[0] = 1'b1;
    for (int k = 0; k < 15; k++) tick();
  endtask

  task automatic test_long_hold(input int ch);
    logic tog0, tog1;
    logic [3:0] got, exp;
    tog0 = m_tog[ch];
    tog1 = tog0 ^ !sel[ch];
    sw[ch] = 1'b0;
    for (int k = 1; k <= 130; k++) begin
      tick();
      got = {st[ch], td[ch], lh[ch], tg[ch]};
      exp = {(k < 10), (k == 10), (k == 30), tog0 ^ (!sel[ch] && k >= 10)};
      n_vec++;
      if (got !== exp) begin
        n_err++; $display("FAIL hold_press ch=%0d k=%0d got %b want %b", ch, k, got, exp);
      end
    end
    sw[ch] = 1'b1;
    for (int k = 1; k <= 15; k++) begin
      tick();
      got = {st[ch], tu[ch], lh[ch], tg[ch]};
      exp = {(k >= 10), (k == 10), 1'b0, tog1 ^ (sel[ch] && k >= 10)};
      n_vec++;
      if (got !== exp) begin
        n_err++; $display("FAIL hold_release ch=%0d k=%0d got %b want %b", ch, k, got, exp);
      end
      n_vec++;
      if ({st, tu, td, tg, lh} !== {m_state, m_up, m_dn, m_tog, m_long}) begin
        n_err++; $display("FAIL hold_model ch=%0d k=%0d got %b want %b", ch, k, {st, tu, td, tg, lh}, {m_state, m_up, m_dn, m_tog, m_long});
      end
    end
  endtask

  task automatic test_simultaneous();
    logic [1:0] tog0;
    logic [5:0] exp;
    tog0 = m_tog;
    sw = 2'b00;
    for (int k = 1; k <= 12; k++) begin
      tick();
      exp = {((k >= 10) ? 2'b00 : 2'b11), ((k == 10) ? 2'b11 : 2'b00), tog0 ^ ((k >= 10) ? ~sel : 2'b00)};
      n_vec++;
      if ({st, td, tg} !== exp) begin
        n_err++; $display("FAIL simultaneous k=%0d got %b want %b", k, {st, td, tg}, exp);
      end
    end
    sw = 2'b11;
    for (int k = 0; k < 15; k++) begin
      tick();
      n_vec++;
      if ({st, tu, td, tg, lh} !== {m_state, m_up, m_dn, m_tog, m_long}) begin
        n_err++; $display("FAIL simul_model k=%0d got %b want %b", k, {st, tu, td, tg, lh}, {m_state, m_up, m_dn, m_tog, m_long});
      end
    end
  endtask

  task automatic test_random();
    int per;
    per = 10;
    for (int n = 0; n < 3000; n++) begin
      if (n % 150 == 0) begin
        case ($urandom_range(0, 2))
          0: per = 3;
          1: per = 12;
          default: per = 45;
        endcase
      end
      for (int c = 0; c < 2; c++) begin
        if ($urandom_range(0, per - 1) == 0) sw[c] = ~sw[c];
        if ($urandom_range(0, 99) == 0) sel[c] = ~sel[c];
      end
      tick();
      n_vec++;
      if ({st, tu, td, tg, lh} !== {m_state, m_up, m_dn, m_tog, m_long}) begin
        n_err++; $display("FAIL random n=%0d got %b want %b", n, {st, tu, td, tg, lh}, {m_state, m_up, m_dn, m_tog, m_long});
      end
    end
    sw = 2'b11;
    sel = 2'b10;
    for (int k = 0; k < 30; k++) begin
      tick();
      n_vec++;
      if ({st, tu, td, tg, lh} !== {m_state, m_up, m_dn, m_tog, m_long}) begin
        n_err++; $display("FAIL random_settle k=%0d got %b want %b", k, {st, tu, td, tg, lh}, {m_state, m_up, m_dn, m_tog, m_long});
      end
    end
  endtask

  task automatic test_reset_mid();
    sw[0] = 1'b0;
    for (int k = 0; k < 7; k++) tick();
    #2 RST = 1'b1;
    #1;
    n_vec++;
    if ({st, tu, td, tg, lh} !== 10'b11_00_00_00_00) begin
      n_err++; $display("FAIL reset_mid got %b want %b", {st, tu, td, tg, lh}, 10'b11_00_00_00_00);
    end
    tick(); tick();
    RST = 1'b0;
    for (int k = 1; k <= 12; k++) begin
      tick();
      n_vec++;
      if ({st[0], td[0], tg[0]} !== {(k < 10), (k == 10), (k >= 10)}) begin
        n_err++; $display("FAIL reset_recover k=%0d got %b want %b", k, {st[0], td[0], tg[0]}, {(k < 10), (k == 10), (k >= 10)});
      end
      n_vec++;
      if ({st, tu, td, tg, lh} !== {m_state, m_up, m_dn, m_tog, m_long}) begin
        n_err++; $display("FAIL reset_model k=%0d got %b want %b", k, {st, tu, td, tg, lh}, {m_state, m_up, m_dn, m_tog, m_long});
      end
    end
    sw[0] = 1'b1;
    for (int k = 0; k < 15; k++) tick();
  endtask

  task automatic test_no_filter();
    logic [4:0] exp;
    sw_b = 1'b0;
    for (int k = 1; k <= 1000; k++) begin
      tick();
      exp = {(k < 3), (k == 3), 1'b0, 1'b0, (k >= 3)};
      n_vec++;
      if ({st_b, td_b, tu_b, lh_b, tg_b} !== exp) begin
        n_err++; $display("FAIL no_filter_hold k=%0d got %b want %b", k, {st_b, td_b, tu_b, lh_b, tg_b}, exp);
      end
    end
    sw_b = 1'b1;
    for (int k = 1; k <= 8; k++) begin
      tick();
      sw_b = 1'b0;
      exp = {(k == 3), (k == 4), (k == 3), 1'b0, (k < 4)};
      n_vec++;
      if ({st_b, td_b, tu_b, lh_b, tg_b} !== exp) begin
        n_err++; $display("FAIL no_filter_glitch k=%0d got %b want %b", k, {st_b, td_b, tu_b, lh_b, tg_b}, exp);
      end
    end
  endtask

  initial begin
    test_reset();
    test_clean_press();
    test_bounce();
    test_long_hold(0);
    test_long_hold(1);
    test_simultaneous();
    test_random();
    test_reset_mid();
    test_no_filter();
    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule
